f32_unit_arbiter: RTL

F32_UNIT_ARBITER -- requirements
Module: f32_unit_arbiter

---
 rtl/f32_sched_pkg.sv | 17 +
 rtl/tag_delay.sv | 31 +++
 rtl/f32_unit_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/f32_sched_pkg.sv
// Shared scheduling definitions for the FP-unit arbiter: per-operator latencies
// and the tag that follows each issued operation down the unit's pipeline.
package f32_sched_pkg;

    localparam int ADD_LAT = 5;
    localparam int SUB_LAT = 5;
    localparam int MUL_LAT = 4;

    // Wide enough for the largest supported requester count (16).
    localparam int IDX_W = 4;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] index;
    } tag_t;

endpackage

// File: rtl/tag_delay.sv
// Fixed-depth shift register carrying {valid, index} tags alongside the FP unit,
// so each result can be routed back to the requester that issued it.
module tag_delay
    import f32_sched_pkg::*;
#(
    parameter int DEPTH = 5
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t pipe [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign tag_out = pipe[DEPTH-1];

endmodule

// File: rtl/f32_unit_arbiter.sv
// Round-robin arbiter sharing one pipelined FP unit among NUM_REQ requesters;
// results are steered back to their owner through a tag pipeline.
module f32_unit_arbiter
    import f32_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = ADD_LAT,
    parameter int WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [WIDTH-1:0]         fu_a,
    output logic [WIDTH-1:0]         fu_b,
    output logic                     fu_t,
    input  logic [WIDTH-1:0]         fu_out,
    output logic [4:0]               in_flight,
    output logic                     idle
);

    localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]   NREQ_W   = (IDX_W + 1)'(NUM_REQ);

    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     fu_idx;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     grant_off;
    logic [IDX_W:0]       grant_sum;
    logic [2*NUM_REQ-1:0] dbl_valid;
    logic [NUM_REQ-1:0]   rot_valid;
    logic                 grant_any;
    logic                 fire;
    logic                 ret;
    tag_t                 tag_entry;
    tag_t                 tag_exit;

    // Rotate requests so bit 0 is the requester just after ptr; the lowest set
    // bit is the winner. A 4-bit ptr+1 wraps correctly even for NUM_REQ=16.
    always_comb begin
        dbl_valid = {req_valid, req_valid} >> (ptr + 1'b1);
        rot_valid = dbl_valid[NUM_REQ-1:0];
        grant_off = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rot_valid[j]) begin
                grant_off = IDX_W'(j);
            end
        end
        grant_sum = {1'b0, ptr} + (IDX_W + 1)'(1) + {1'b0, grant_off};
        if (grant_sum >= NREQ_W) begin
            grant_sum = grant_sum - NREQ_W;
        end
        grant_idx = grant_sum[IDX_W-1:0];
        grant_any = (|rot_valid) && rst;
        req_ready = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
    end

    assign fire = |(req_valid & req_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr    <= PTR_INIT;
            fu_a   <= '0;
            fu_b   <= '0;
            fu_t   <= 1'b0;
            fu_idx <= '0;
        end else begin
            fu_t <= fire;
            if (fire) begin
                ptr    <= grant_idx;
                fu_idx <= grant_idx;
                fu_a   <= req_a[grant_idx*WIDTH +: WIDTH];
                fu_b   <= req_b[grant_idx*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        tag_entry       = '0;
        tag_entry.valid = fu_t;
        tag_entry.index = fu_idx;
    end

    tag_delay #(
        .DEPTH (LATENCY)
    ) u_tag_delay (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_entry),
        .tag_out (tag_exit)
    );

    assign ret       = tag_exit.valid;
    assign rsp_valid = ret ? (NUM_REQ'(1) << tag_exit.index) : '0;
    assign rsp_data  = fu_out;

    // An operation counts from its acceptance edge until the edge ending its result cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_flight <= '0;
        end else begin
            case ({fire, ret})
                2'b10:   in_flight <= in_flight + 5'd1;
                2'b01:   in_flight <= in_flight - 5'd1;
                default: in_flight <= in_flight;
            endcase
        end
    end

    assign idle = (in_flight == 5'd0) && (req_ready == '0);

endmodule
